// File: rtl/max_stream_tracker_if.sv
// Sample-in / result-out handshake bundle for max_stream_tracker.
// The master drives samples and out_ready; the slave returns in_ready and the result.
interface max_stream_tracker_if #(
    parameter int WIDTH = 8,
    parameter int WIN   = 16
);
    localparam int IW = $clog2(WIN);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_max;
    logic [IW-1:0]    out_idx;
    logic [IW:0]      out_cnt;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_max, out_idx, out_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_max, out_idx, out_cnt
    );
endinterface

// File: rtl/max_stream_tracker.sv
// Windowed running-maximum tracker: reports the first maximal sample of each
// window (WIN samples or fewer via in_last), its index and the window length.
module max_stream_tracker #(
    parameter int WIDTH = 8,
    parameter int WIN   = 16,
    parameter int DROP  = 0
) (
    input logic                clk,
    input logic                rst,
    max_stream_tracker_if.slave bus
);
    localparam int IW = $clog2(WIN);
    localparam logic [IW:0] LAST_CNT = (IW + 1)'(WIN - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           r_state,     w_state_nxt;
    logic [IW:0]      r_cnt,       w_cnt_nxt;
    logic [WIDTH-1:0] r_best,      w_best_nxt;
    logic [IW-1:0]    r_best_idx,  w_best_idx_nxt;
    logic [WIDTH-1:0] r_out_max,   w_out_max_nxt;
    logic [IW-1:0]    r_out_idx,   w_out_idx_nxt;
    logic [IW:0]      r_out_cnt,   w_out_cnt_nxt;
    logic             r_in_ready,  w_in_ready_nxt;
    logic             r_out_valid, w_out_valid_nxt;

    logic             w_in_xfer;
    logic             w_take;
    logic [WIDTH-1:0] w_upd_best;
    logic [IW-1:0]    w_upd_idx;
    logic [IW:0]      w_cnt_inc;

    // Strict compare on the masked keys so ties keep the earlier sample.
    assign w_in_xfer  = bus.in_valid && r_in_ready;
    assign w_take     = (r_cnt == '0) || ((bus.in_data >> DROP) > (r_best >> DROP));
    assign w_upd_best = w_take ? bus.in_data : r_best;
    assign w_upd_idx  = w_take ? r_cnt[IW-1:0] : r_best_idx;
    assign w_cnt_inc  = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_best_nxt      = r_best;
        w_best_idx_nxt  = r_best_idx;
        w_out_max_nxt   = r_out_max;
        w_out_idx_nxt   = r_out_idx;
        w_out_cnt_nxt   = r_out_cnt;
        w_in_ready_nxt  = r_in_ready;
        w_out_valid_nxt = r_out_valid;

        case (r_state)
            ACCUM: begin
                if (w_in_xfer) begin
                    w_best_nxt     = w_upd_best;
                    w_best_idx_nxt = w_upd_idx;
                    w_cnt_nxt      = w_cnt_inc;
                    if ((r_cnt == LAST_CNT) || bus.in_last) begin
                        w_out_max_nxt   = w_upd_best;
                        w_out_idx_nxt   = w_upd_idx;
                        w_out_cnt_nxt   = w_cnt_inc;
                        w_cnt_nxt       = '0;
                        w_state_nxt     = HOLD;
                        w_in_ready_nxt  = 1'b0;
                        w_out_valid_nxt = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    w_state_nxt     = ACCUM;
                    w_in_ready_nxt  = 1'b1;
                    w_out_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_cnt       <= '0;
            r_best      <= '0;
            r_best_idx  <= '0;
            r_out_max   <= '0;
            r_out_idx   <= '0;
            r_out_cnt   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_best      <= w_best_nxt;
            r_best_idx  <= w_best_idx_nxt;
            r_out_max   <= w_out_max_nxt;
            r_out_idx   <= w_out_idx_nxt;
            r_out_cnt   <= w_out_cnt_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_max   = r_out_max;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_cnt   = r_out_cnt;
endmodule

// File: tb/tb_max_stream_tracker.sv
// Four tracker configurations share one input stream; each is checked against a
// window-level reference model, plus directed tables and hand-written sequences.
module tb_max_stream_tracker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v   = 1'b0;
    logic [7:0] d   = '0;
    logic       l   = 1'b0;
    logic       o   = 1'b0;

    always #5 clk = ~clk;

    // 0: WIN=4 DROP=0, 1: WIN=4 DROP=2, 2: WIN=16 DROP=0, 3: WIN=16 DROP=3
    max_stream_tracker_if #(.WIDTH(8), .WIN(4))  if0 ();
    max_stream_tracker_if #(.WIDTH(8), .WIN(4))  if1 ();
    max_stream_tracker_if #(.WIDTH(8), .WIN(16)) if2 ();
    max_stream_tracker_if #(.WIDTH(8), .WIN(16)) if3 ();

    max_stream_tracker #(.WIDTH(8), .WIN(4),  .DROP(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    max_stream_tracker #(.WIDTH(8), .WIN(4),  .DROP(2)) u1 (.clk(clk), .rst(rst), .bus(if1));
    max_stream_tracker #(.WIDTH(8), .WIN(16), .DROP(0)) u2 (.clk(clk), .rst(rst), .bus(if2));
    max_stream_tracker #(.WIDTH(8), .WIN(16), .DROP(3)) u3 (.clk(clk), .rst(rst), .bus(if3));

    assign if0.in_valid = v; assign if0.in_data = d; assign if0.in_last = l; assign if0.out_ready = o;
    assign if1.in_valid = v; assign if1.in_data = d; assign if1.in_last = l; assign if1.out_ready = o;
    assign if2.in_valid = v; assign if2.in_data = d; assign if2.in_last = l; assign if2.out_ready = o;
    assign if3.in_valid = v; assign if3.in_data = d; assign if3.in_last = l; assign if3.out_ready = o;

    logic       a_ir  [4];
    logic       a_ov  [4];
    logic [7:0] a_max [4];
    logic [3:0] a_idx [4];
    logic [4:0] a_cnt [4];

    assign a_ir[0] = if0.in_ready; assign a_ov[0] = if0.out_valid; assign a_max[0] = if0.out_max;
    assign a_ir[1] = if1.in_ready; assign a_ov[1] = if1.out_valid; assign a_max[1] = if1.out_max;
    assign a_ir[2] = if2.in_ready; assign a_ov[2] = if2.out_valid; assign a_max[2] = if2.out_max;
    assign a_ir[3] = if3.in_ready; assign a_ov[3] = if3.out_valid; assign a_max[3] = if3.out_max;
    assign a_idx[0] = {2'b00, if0.out_idx}; assign a_cnt[0] = {2'b00, if0.out_cnt};
    assign a_idx[1] = {2'b00, if1.out_idx}; assign a_cnt[1] = {2'b00, if1.out_cnt};
    assign a_idx[2] = if2.out_idx;          assign a_cnt[2] = if2.out_cnt;
    assign a_idx[3] = if3.out_idx;          assign a_cnt[3] = if3.out_cnt;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: buffer the window's samples, pick the winner when it closes.
    int         m_win  [4] = '{4, 4, 16, 16};
    int         m_drop [4] = '{0, 2, 0, 3};
    logic [7:0] m_buf  [4][16];
    int         m_n    [4] = '{0, 0, 0, 0};
    bit         m_hold [4] = '{0, 0, 0, 0};
    int         m_max  [4] = '{0, 0, 0, 0};
    int         m_idx  [4] = '{0, 0, 0, 0};
    int         m_cnt  [4] = '{0, 0, 0, 0};
    int         n_xfer [4] = '{0, 0, 0, 0};
    int         n_out  [4] = '{0, 0, 0, 0};

    task automatic chk(input string nm, input int k, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, k, $time, act, exp);
        end
    endtask

    task automatic model_update(input int k);
        int best;
        if (rst) begin
            m_n[k] = 0; m_hold[k] = 0; m_max[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
        end else if (m_hold[k]) begin
            if (o) m_hold[k] = 0;
        end else if (v) begin
            m_buf[k][m_n[k]] = d;
            m_n[k]++;
            if (m_n[k] == m_win[k] || l) begin
                best = 0;
                for (int i = 1; i < m_n[k]; i++)
                    if ((m_buf[k][i] >> m_drop[k]) > (m_buf[k][best] >> m_drop[k])) best = i;
                m_max[k]  = m_buf[k][best];
                m_idx[k]  = best;
                m_cnt[k]  = m_n[k];
                m_n[k]    = 0;
                m_hold[k] = 1;
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 4; k++) begin
            chk("in_ready",  k, int'(a_ir[k]),  int'(!m_hold[k]));
            chk("out_valid", k, int'(a_ov[k]),  int'(m_hold[k]));
            chk("out_max",   k, int'(a_max[k]), m_max[k]);
            chk("out_idx",   k, int'(a_idx[k]), m_idx[k]);
            chk("out_cnt",   k, int'(a_cnt[k]), m_cnt[k]);
        end
    endtask

    // Called at the falling edge: drive, tally handshakes, clock, model, check.
    task automatic step(input logic r_i, input logic v_i, input logic [7:0] d_i,
                        input logic l_i, input logic o_i);
        rst = r_i; v = v_i; d = d_i; l = l_i; o = o_i;
        #1;
        if (!r_i) begin
            for (int k = 0; k < 4; k++) begin
                if (a_ir[k] && v_i) n_xfer[k]++;
                if (a_ov[k] && o_i) n_out[k] += int'(a_cnt[k]);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 4; k++) model_update(k);
        @(negedge clk);
        check_model();
    endtask

    task automatic hchk(input string nm, input logic e_ir, input logic e_ov,
                        input int e_max, input int e_idx, input int e_cnt);
        chk({nm, ".in_ready"},  2, int'(a_ir[2]),  int'(e_ir));
        chk({nm, ".out_valid"}, 2, int'(a_ov[2]),  int'(e_ov));
        chk({nm, ".out_max"},   2, int'(a_max[2]), e_max);
        chk({nm, ".out_idx"},   2, int'(a_idx[2]), e_idx);
        chk({nm, ".out_cnt"},   2, int'(a_cnt[2]), e_cnt);
    endtask

    typedef struct {
        logic       r, v;
        logic [7:0] d;
        logic       l, o;
        logic       e_ir, e_ov;
        int         e_max, e_idx, e_cnt;
        int         e2_max, e2_idx;
    } vec_t;

    function automatic vec_t mk(input logic r_i, input logic v_i, input logic [7:0] d_i,
                                input logic o_i, input logic e_ir, input logic e_ov,
                                input int e_max, input int e_idx, input int e_cnt,
                                input int e2_max, input int e2_idx);
        vec_t t;
        t.r = r_i; t.v = v_i; t.d = d_i; t.l = 1'b0; t.o = o_i;
        t.e_ir = e_ir; t.e_ov = e_ov; t.e_max = e_max; t.e_idx = e_idx; t.e_cnt = e_cnt;
        t.e2_max = e2_max; t.e2_idx = e2_idx;
        return t;
    endfunction

    vec_t tbl [19];

    initial begin
        // Rows checked on WIN=4 instances: [0] DROP=0 fully, [1] DROP=2 max/idx.
        tbl[0]  = mk(1, 0, 8'd0,   1, 1, 0,   0, 0, 0,   0, 0);
        tbl[1]  = mk(0, 1, 8'd5,   1, 1, 0,   0, 0, 0,   0, 0);
        tbl[2]  = mk(0, 1, 8'd200, 1, 1, 0,   0, 0, 0,   0, 0);
        tbl[3]  = mk(0, 1, 8'd17,  1, 1, 0,   0, 0, 0,   0, 0);
        tbl[4]  = mk(0, 1, 8'd200, 1, 0, 1, 200, 1, 4, 200, 1);
        tbl[5]  = mk(0, 0, 8'd0,   1, 1, 0, 200, 1, 4, 200, 1);
        tbl[6]  = mk(0, 1, 8'd12,  1, 1, 0, 200, 1, 4, 200, 1);
        tbl[7]  = mk(0, 1, 8'd14,  1, 1, 0, 200, 1, 4, 200, 1);
        tbl[8]  = mk(0, 1, 8'd13,  1, 1, 0, 200, 1, 4, 200, 1);
        tbl[9]  = mk(0, 1, 8'd3,   1, 0, 1,  14, 1, 4,  12, 0);
        tbl[10] = mk(0, 0, 8'd0,   1, 1, 0,  14, 1, 4,  12, 0);
        tbl[11] = mk(0, 1, 8'd9,   1, 1, 0,  14, 1, 4,  12, 0);
        tbl[12] = mk(0, 1, 8'd3,   1, 1, 0,  14, 1, 4,  12, 0);
        tbl[13] = mk(1, 0, 8'd0,   1, 1, 0,   0, 0, 0,   0, 0);
        tbl[14] = mk(0, 1, 8'd1,   1, 1, 0,   0, 0, 0,   0, 0);
        tbl[15] = mk(0, 1, 8'd2,   1, 1, 0,   0, 0, 0,   0, 0);
        tbl[16] = mk(0, 1, 8'd3,   1, 1, 0,   0, 0, 0,   0, 0);
        tbl[17] = mk(0, 1, 8'd4,   1, 0, 1,   4, 3, 4,   4, 3);
        tbl[18] = mk(0, 0, 8'd0,   1, 1, 0,   4, 3, 4,   4, 3);

        @(negedge clk);
        step(1, 0, 8'd0, 0, 0);
        step(1, 0, 8'd0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].o);
            chk("tbl.in_ready",  i, int'(a_ir[0]),  int'(tbl[i].e_ir));
            chk("tbl.out_valid", i, int'(a_ov[0]),  int'(tbl[i].e_ov));
            chk("tbl.out_max",   i, int'(a_max[0]), tbl[i].e_max);
            chk("tbl.out_idx",   i, int'(a_idx[0]), tbl[i].e_idx);
            chk("tbl.out_cnt",   i, int'(a_cnt[0]), tbl[i].e_cnt);
            chk("tbl.drop2_max", i, int'(a_max[1]), tbl[i].e2_max);
            chk("tbl.drop2_idx", i, int'(a_idx[1]), tbl[i].e2_idx);
        end

        // Early termination on WIN=16, then a single-sample window.
        step(1, 0, 8'd0, 0, 1);
        step(0, 1, 8'd7, 0, 0);
        step(0, 1, 8'd9, 1, 0);
        hchk("early", 0, 1, 9, 1, 2);
        step(0, 0, 8'd0, 0, 1);
        hchk("early_ack", 1, 0, 9, 1, 2);
        step(0, 1, 8'h00, 1, 0);
        hchk("single", 0, 1, 0, 0, 1);

        // Backpressure with 0xFF offered while the result is held.
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 8'hFF, 0, 0);
            hchk("bp_hold", 0, 1, 0, 0, 1);
        end
        step(0, 1, 8'hFF, 0, 1);
        hchk("bp_release", 1, 0, 0, 0, 1);
        step(0, 1, 8'hFF, 1, 0);
        hchk("bp_next", 0, 1, 255, 0, 1);
        step(0, 0, 8'd0, 0, 1);

        // Random soak with conservation accounting from a clean reset.
        step(1, 0, 8'd0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            n_xfer[k] = 0;
            n_out[k]  = 0;
        end
        for (int i = 0; i < 10000; i++)
            step(0, ($urandom_range(0, 9) < 7), 8'($urandom),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 6));
        for (int i = 0; i < 4; i++) step(0, 0, 8'd0, 0, 1);
        for (int k = 0; k < 4; k++)
            chk("conservation", k, n_xfer[k], n_out[k] + m_n[k]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/max_stream_tracker.md
Name: max_stream_tracker

Overview:
- Sequential, parametrised successor to the combinational max partitions.
- Consumes a stream of unsigned WIDTH-bit samples through a valid/ready handshake and tracks the running maximum over a window of WIN samples, or fewer if in_last cuts the window short.
- Emits the winning value, its index and the sample count through a registered output handshake.
- DROP sets an approximate mode: the DROP low bits are ignored when samples are compared.

Parameters:
- WIDTH, 8, sample width in bits (>=2)
- WIN, 16, samples per window (>=2)
- DROP, 0, LSBs masked in comparison (0 = exact; 0 <= DROP < WIDTH)
- IW, $clog2(WIN), index width (derived, localparam)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  sample valid
- in_ready  output  1  block can accept a sample
- in_data  input  WIDTH  unsigned sample
- in_last  input  1  sample closes the window early
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_max  output  WIDTH  full-precision value of the winning sample
- out_idx  output  IW  position of the winner within the window (0-based)
- out_cnt  output  IW+1  samples in the window (1..WIN)

Behaviour:
- Reset: one clock is synchronous and reset is synchronous, active-high (rst sampled on rising clk).
  - Reset values: state=ACCUM, in_ready=1, out_valid=0, out_max=0, out_idx=0, out_cnt=0, internal cnt=0, best=0, best_idx=0.
  - rst asserted mid-window or in HOLD discards all partial and pending results.
- Transfer rule: a transfer occurs when valid && ready are both high on a rising edge.
- Comparison: key(x) = x >> DROP.
  - A sample replaces best when cnt==0, or when key(in_data) > key(best) (strict).
  - Ties keep the earlier sample, so the first occurrence wins.
  - best always holds the full unmasked sample.
- State ACCUM: in_ready=1, out_valid=0.
  - On each input transfer: update best/best_idx with in_data/cnt, then cnt++.
  - If the transfer is the WIN-th sample (cnt==WIN-1) or in_last=1: load out_max/out_idx/out_cnt from the updated values, cnt<=0, go to HOLD.
  - out_* registers are loaded in the same edge, so out_valid rises the cycle after the closing transfer (latency 1).
- State HOLD: in_ready=0, out_valid=1; out_* stable while out_valid && !out_ready.
  - On an output transfer: out_valid<=0, go to ACCUM. in_ready is 1 in the next cycle.
  - No input is accepted in HOLD. Throughput is therefore one window per (window length + 1) cycles with out_ready tied high.
- in_valid=0 cycles in ACCUM: no state change. There is no window timeout.
- in_last with cnt==0 gives a single-sample window: out_cnt=1, out_idx=0.
- in_last coinciding with the WIN-th sample gives a single result with out_cnt=WIN.
- Arithmetic: cnt is IW+1 bits wide and never exceeds WIN; there is no wrap beyond WIN.
- out_* hold their last values after the handshake until the next window closes.
- in_data is ignored when in_valid=0. X on in_data is permitted then.
- All outputs are registered. There is no combinational path from in_* to out_* or from out_ready to in_ready.

Test Plan:
- Reset mid-window: WIN=4, send 9,3 then assert rst for 1 cycle, then send 1,2,3,4.
  - Expect out_valid=0 throughout the reset.
  - Then one result: out_max=4, out_idx=3, out_cnt=4. Samples 9 and 3 have no effect.
- Exact full window: WIDTH=8, WIN=4, DROP=0, out_ready=1, send 5,200,17,200.
  - Expect out_valid one cycle after the 4th transfer.
  - out_max=200, out_idx=1 (tie keeps first), out_cnt=4.
  - in_ready=0 for exactly one cycle.
- Approximate mode: DROP=2, send 12,14,13,3.
  - Keys are 3,3,3,0, so expect out_max=12, out_idx=0, out_cnt=4.
  - With DROP=0 the same stream gives out_max=14, out_idx=1.
- Early termination: WIN=16, send 7,9(in_last=1).
  - Expect out_max=9, out_idx=1, out_cnt=2. A following window starts at idx 0.
  - Single in_last sample 0x00 gives out_max=0, out_idx=0, out_cnt=1.
- Output backpressure: hold out_ready=0 for 10 cycles after the result appears while in_valid=1 with data 0xFF.
  - Expect out_* stable, in_ready=0, no sample consumed.
  - After out_ready=1 for one cycle, in_ready=1 next cycle and 0xFF is counted in the new window at idx 0.
- Random soak: 10k samples with random in_valid/out_ready/in_last, DROP in {0,3}.
  - Scoreboard model matches every out_max/out_idx/out_cnt.
  - No sample is lost or duplicated (sum of out_cnt equals input transfers).
